// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FPU byte-serial front-end sequencer.
package fpu_seq_pkg;

  // Sequencer states; the encoding is visible on state_dbg.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_READ   = 3'd5
  } state_e;

  // FPU operation codes as driven on fpu_op.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } opcode_e;

  // IEEE exception flag layout {NV,DZ,OF,UF,NX}.
  localparam int FLAGS_W = 5;
  localparam int FLG_NV  = 4;
  localparam int FLG_DZ  = 3;
  localparam int FLG_OF  = 2;
  localparam int FLG_UF  = 1;
  localparam int FLG_NX  = 0;

endpackage

// File: rtl/fpu_strobe_edge.sv
// Rising-edge detector for a level host strobe. The history register
// resets high so a strobe already asserted at reset release is not an edge.
module fpu_strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  output logic rise
);

  logic stb_q;

  // Strobe history, one cycle behind the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q <= 1'b1;
    end else begin
      stb_q <= stb;
    end
  end

  assign rise = stb & ~stb_q;

endmodule

// File: rtl/fpu_io_sequencer.sv
// Byte-serial front end for the FPU core: collects opcode and operands from
// host writes, issues one operation, waits for done (with timeout) and
// streams the result back MSB byte first under host read strobes.
module fpu_io_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             wr_stb,
  input  logic             rd_stb,
  output logic [7:0]       data_out,
  output logic             busy,
  output logic             res_valid,
  output logic             err,
  output logic [4:0]       flags_out,
  output logic [2:0]       state_dbg,
  output logic [1:0]       fpu_op,
  output logic [WIDTH-1:0] fpu_a,
  output logic [WIDTH-1:0] fpu_b,
  output logic             fpu_start,
  input  logic             fpu_done,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic [4:0]       fpu_flags
);

  localparam int NB  = WIDTH / 8;
  localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0]     ST_IDLE   = S_IDLE;
  localparam logic [2:0]     ST_LOAD_A = S_LOAD_A;
  localparam logic [2:0]     ST_LOAD_B = S_LOAD_B;
  localparam logic [2:0]     ST_ISSUE  = S_ISSUE;
  localparam logic [2:0]     ST_WAIT   = S_WAIT;
  localparam logic [2:0]     ST_READ   = S_READ;
  localparam logic [CW-1:0]  LAST_BYTE = CW'(NB - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYC - 1);

  // Shift one byte into the LSB end of an operand.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic [7:0] b);
    logic [WIDTH+7:0] w;
    w = {cur, b};
    return w[WIDTH-1:0];
  endfunction

  // Select result byte idx, idx 0 being the most significant byte.
  function automatic logic [7:0] byte_at(input logic [WIDTH-1:0] v,
                                         input logic [CW-1:0] idx);
    logic [WIDTH-1:0] s;
    s = v >> (8 * (NB - 1 - int'(idx)));
    return s[7:0];
  endfunction

  logic             wr_rise;
  logic             rd_rise;
  logic [2:0]       state,  state_n;
  logic [CW-1:0]    cnt,    cnt_n;
  logic [TCW-1:0]   tcnt,   tcnt_n;
  logic [WIDTH-1:0] result, result_n;
  logic [4:0]       flags_n;
  logic             err_n;
  logic [1:0]       op_n;
  logic [WIDTH-1:0] a_n, b_n;

  fpu_strobe_edge u_wr_edge (.clk(clk), .rst(rst), .stb(wr_stb), .rise(wr_rise));
  fpu_strobe_edge u_rd_edge (.clk(clk), .rst(rst), .stb(rd_stb), .rise(rd_rise));

  assign state_dbg = state;

  // Next-state and datapath update decisions for the sequencer.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    tcnt_n   = tcnt;
    result_n = result;
    flags_n  = flags_out;
    err_n    = err;
    op_n     = fpu_op;
    a_n      = fpu_a;
    b_n      = fpu_b;
    case (state)
      ST_IDLE: begin
        if (wr_rise) begin
          op_n    = data_in[1:0];
          err_n   = 1'b0;
          cnt_n   = '0;
          state_n = ST_LOAD_A;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD_A: begin
        if (wr_rise) begin
          a_n = shift_in(fpu_a, data_in);
          if (cnt == LAST_BYTE) begin
            cnt_n   = '0;
            state_n = ST_LOAD_B;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end else begin
          state_n = ST_LOAD_A;
        end
      end
      ST_LOAD_B: begin
        if (wr_rise) begin
          b_n = shift_in(fpu_b, data_in);
          if (cnt == LAST_BYTE) begin
            cnt_n   = '0;
            state_n = ST_ISSUE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end else begin
          state_n = ST_LOAD_B;
        end
      end
      ST_ISSUE: begin
        tcnt_n  = '0;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the timeout cycle still counts as success.
        if (fpu_done) begin
          result_n = fpu_result;
          flags_n  = fpu_flags;
          err_n    = 1'b0;
          cnt_n    = '0;
          state_n  = ST_READ;
        end else if (tcnt == TO_LAST) begin
          result_n = '0;
          flags_n  = 5'b00000;
          err_n    = 1'b1;
          cnt_n    = '0;
          state_n  = ST_READ;
        end else begin
          tcnt_n = tcnt + TCW'(1);
        end
      end
      ST_READ: begin
        // A new opcode write abandons the rest of the result.
        if (wr_rise) begin
          op_n    = data_in[1:0];
          err_n   = 1'b0;
          cnt_n   = '0;
          state_n = ST_LOAD_A;
        end else if (rd_rise) begin
          if (cnt == LAST_BYTE) begin
            cnt_n   = '0;
            state_n = ST_IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end else begin
          state_n = ST_READ;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, datapath registers and registered host/FPU outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tcnt      <= '0;
      result    <= '0;
      flags_out <= 5'b00000;
      err       <= 1'b0;
      fpu_op    <= 2'b00;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_start <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      data_out  <= 8'h00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tcnt      <= tcnt_n;
      result    <= result_n;
      flags_out <= flags_n;
      err       <= err_n;
      fpu_op    <= op_n;
      fpu_a     <= a_n;
      fpu_b     <= b_n;
      fpu_start <= (state_n == ST_ISSUE);
      busy      <= (state_n == ST_ISSUE) || (state_n == ST_WAIT);
      res_valid <= (state_n == ST_READ);
      data_out  <= (state_n == ST_READ) ? byte_at(result_n, cnt_n) : 8'h00;
    end
  end

endmodule

// File: tb/tb_fpu_io_sequencer.sv
// Directed bench for fpu_io_sequencer with a hand-driven FPU stub.
module tb_fpu_io_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        wr_stb;
  logic        rd_stb;
  logic [7:0]  data_out;
  logic        busy;
  logic        res_valid;
  logic        err;
  logic [4:0]  flags_out;
  logic [2:0]  state_dbg;
  logic [1:0]  fpu_op;
  logic [15:0] fpu_a;
  logic [15:0] fpu_b;
  logic        fpu_start;
  logic        fpu_done;
  logic [15:0] fpu_result;
  logic [4:0]  fpu_flags;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  int start_snap;

  fpu_io_sequencer #(.WIDTH(16), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_stb(wr_stb), .rd_stb(rd_stb),
    .data_out(data_out), .busy(busy), .res_valid(res_valid), .err(err),
    .flags_out(flags_out), .state_dbg(state_dbg), .fpu_op(fpu_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_start(fpu_start), .fpu_done(fpu_done),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags)
  );

  always #5 clk = ~clk;

  // Count every cycle in which the issue pulse is high.
  always @(posedge clk) begin
    if (fpu_start) start_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    data_in = b;
    wr_stb  = 1'b1;
    tick();
    wr_stb  = 1'b0;
    tick();
  endtask

  task automatic rd_pulse();
    rd_stb = 1'b1;
    tick();
    rd_stb = 1'b0;
    tick();
  endtask

  task automatic fpu_reply(input logic [15:0] res, input logic [4:0] flg);
    fpu_done   = 1'b1;
    fpu_result = res;
    fpu_flags  = flg;
    tick();
    fpu_done   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_stb = 1'b1; rd_stb = 1'b0; data_in = 8'h03;
    fpu_done = 1'b0; fpu_result = 16'h0000; fpu_flags = 5'b00000;
    repeat (3) tick();
    check_eq("rst_state", state_dbg, 3'd0);
    check_eq("rst_outs", {busy, res_valid, err, fpu_start, flags_out, data_out}, 17'h0);
    check_eq("rst_regs", {fpu_op, fpu_a, fpu_b}, 34'h0);

    // Strobe held high across reset release is not an edge.
    rst = 1'b0;
    tick(); tick();
    check_eq("no_cap_rst_rel", state_dbg, 3'd0);
    wr_stb = 1'b0;
    tick();

    // Normal add: 1.0 + 2.0 = 3.0 (4200).
    wr_byte(8'h00); wr_byte(8'h3C); wr_byte(8'h00); wr_byte(8'h40); wr_byte(8'h00);
    check_eq("add_wait_state", state_dbg, 3'd4);
    check_eq("add_busy", busy, 1'b1);
    check_eq("add_start_once", start_cnt, 1);
    check_eq("add_a", fpu_a, 16'h3C00);
    check_eq("add_b", fpu_b, 16'h4000);
    check_eq("add_op", fpu_op, 2'b00);
    tick(); tick();
    fpu_reply(16'h4200, 5'b00000);
    check_eq("add_read_state", state_dbg, 3'd5);
    check_eq("add_valid", res_valid, 1'b1);
    check_eq("add_byte0", data_out, 8'h42);
    check_eq("add_busy_off", busy, 1'b0);
    rd_pulse();
    check_eq("add_byte1", data_out, 8'h00);
    check_eq("add_valid1", res_valid, 1'b1);
    rd_pulse();
    check_eq("add_idle", state_dbg, 3'd0);
    check_eq("add_idle_outs", {res_valid, data_out}, 9'h0);

    // Timeout with wr/rd edges injected during WAIT.
    wr_byte(8'h01); wr_byte(8'h12); wr_byte(8'h34); wr_byte(8'h56); wr_byte(8'h78);
    data_in = 8'hAA; wr_stb = 1'b1; tick();
    wr_stb = 1'b0; rd_stb = 1'b1; tick();
    rd_stb = 1'b0; tick();
    check_eq("wait_edge_state", state_dbg, 3'd4);
    check_eq("wait_edge_busy", busy, 1'b1);
    check_eq("wait_edge_op", fpu_op, 2'b01);
    check_eq("wait_edge_b", fpu_b, 16'h5678);
    repeat (4) tick();
    check_eq("to_wait8", state_dbg, 3'd4);
    tick();
    check_eq("to_read", state_dbg, 3'd5);
    check_eq("to_err", err, 1'b1);
    check_eq("to_byte0", data_out, 8'h00);
    check_eq("to_flags", flags_out, 5'b00000);
    rd_pulse();
    check_eq("to_byte1", data_out, 8'h00);
    rd_pulse();
    check_eq("to_idle", state_dbg, 3'd0);
    check_eq("to_err_held", err, 1'b1);

    // Mul with flags; the opcode byte clears err.
    wr_byte(8'h02);
    check_eq("mul_err_clr", err, 1'b0);
    check_eq("mul_load_a", state_dbg, 3'd1);
    wr_byte(8'h40); wr_byte(8'h00); wr_byte(8'h42); wr_byte(8'h00);
    tick();
    fpu_reply(16'h4600, 5'b00001);
    check_eq("mul_op", fpu_op, 2'b10);
    check_eq("mul_flags", flags_out, 5'b00001);
    check_eq("mul_err", err, 1'b0);
    check_eq("mul_byte0", data_out, 8'h46);
    rd_pulse();
    check_eq("mul_byte1", data_out, 8'h00);
    rd_pulse();
    check_eq("mul_idle", state_dbg, 3'd0);

    // READ interrupted by simultaneous wr and rd edges: wr wins.
    wr_byte(8'h00); wr_byte(8'h11); wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h22);
    fpu_reply(16'hABCD, 5'b10000);
    check_eq("int_byte0", data_out, 8'hAB);
    check_eq("int_flags", flags_out, 5'b10000);
    rd_pulse();
    check_eq("int_byte1", data_out, 8'hCD);
    data_in = 8'h03; wr_stb = 1'b1; rd_stb = 1'b1;
    tick();
    check_eq("int_state", state_dbg, 3'd1);
    check_eq("int_op", fpu_op, 2'b11);
    check_eq("int_valid", res_valid, 1'b0);
    check_eq("int_data", data_out, 8'h00);
    wr_stb = 1'b0; rd_stb = 1'b0;
    tick();

    // wr_stb held high for 5 cycles captures exactly one byte.
    data_in = 8'h12; wr_stb = 1'b1; tick();
    data_in = 8'h34; repeat (4) tick();
    wr_stb = 1'b0; tick();
    check_eq("hold_state", state_dbg, 3'd1);
    wr_byte(8'h56);
    check_eq("hold_state_b", state_dbg, 3'd2);
    check_eq("hold_a", fpu_a, 16'h1256);
    wr_byte(8'h00); wr_byte(8'h01);
    check_eq("rw_wait", state_dbg, 3'd4);

    // Reset mid-WAIT, then a late done must be ignored.
    start_snap = start_cnt;
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("mrst_state", state_dbg, 3'd0);
    check_eq("mrst_outs", {busy, res_valid, err, fpu_start, flags_out, data_out}, 17'h0);
    check_eq("mrst_regs", {fpu_op, fpu_a, fpu_b}, 34'h0);
    fpu_reply(16'hFFFF, 5'b11111);
    tick();
    check_eq("late_done_state", state_dbg, 3'd0);
    check_eq("late_done_outs", {res_valid, flags_out, data_out}, 14'h0);
    check_eq("mrst_no_start", start_cnt, start_snap);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
